// File: rtl/pa_spsram_512x39_ctrl.sv
// rtl/pa_spsram_512x39_ctrl.sv - 512x39 single-port SRAM controller with init/invalidate sweep
// Arbitrates one write or read per cycle; INIT and INV states zero every entry with a 512-cycle sweep.
module pa_spsram_512x39_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        inv_req,
  output logic        inv_done,
  output logic        busy,
  input  logic        rd_req,
  input  logic [8:0]  rd_addr,
  output logic        rd_gnt,
  output logic        rd_vld,
  output logic [38:0] rd_data,
  input  logic        wr_req,
  input  logic [8:0]  wr_addr,
  input  logic [38:0] wr_data,
  input  logic [38:0] wr_mask,
  output logic        wr_gnt,
  output logic [8:0]  sram_a,
  output logic        sram_cen,
  output logic        sram_gwen,
  output logic [38:0] sram_wen,
  output logic [38:0] sram_d,
  input  logic [38:0] sram_q
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    INV  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  cnt;
  logic [8:0]  cnt_nxt;
  logic        sweep_last;

  // Last sweep beat: the done pulse lands on the first IDLE cycle that follows.
  assign sweep_last = (state != IDLE) && (cnt == 9'd511);
  assign busy       = (state != IDLE);
  assign rd_data    = sram_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= INIT;
      cnt      <= 9'd0;
      rd_vld   <= 1'b0;
      inv_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rd_vld   <= rd_gnt;
      inv_done <= sweep_last;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = {39{1'b1}};
    sram_a    = 9'd0;
    sram_d    = 39'd0;
    case (state)
      INIT, INV: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = 39'd0;
        sram_a    = cnt;
        if (cnt == 9'd511) begin
          state_nxt = IDLE;
          cnt_nxt   = 9'd0;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
      end
      IDLE: begin
        // Invalidate wins outright and costs one idle SRAM cycle before the sweep.
        if (inv_req) begin
          state_nxt = INV;
          cnt_nxt   = 9'd0;
        end else if (wr_req) begin
          wr_gnt    = 1'b1;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_a    = wr_addr;
          sram_d    = wr_data;
          sram_wen  = ~wr_mask;
        end else if (rd_req) begin
          rd_gnt   = 1'b1;
          sram_cen = 1'b0;
          sram_a   = rd_addr;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = 9'd0;
      end
    endcase
  end

endmodule
